// File: rtl/alu_defs_pkg.sv
// Shared definitions for seq_alu: opcodes, FSM state encoding, default sizes.
// Divider support is gated by the SEQ_ALU_DIV_EN macro in the RTL files.
package alu_defs;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_OPW   = 4;

    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_MUL  = 2;
    localparam int OP_AND  = 3;
    localparam int OP_OR   = 4;
    localparam int OP_XOR  = 5;
    localparam int OP_SLT  = 6;
    localparam int OP_DIVU = 7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/seq_alu_iter.sv
// Iterative shift/accumulate engine shared by multiply and restoring divide.
// Divide mode exists only when SEQ_ALU_DIV_EN is defined.
module seq_alu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             mode_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_nxt,
    output logic [WIDTH-1:0] lo_nxt,
    output logic             last
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, op2_q, op2_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   add_a, add_b, sum;
    logic             add_ci;
`ifdef SEQ_ALU_DIV_EN
    logic             mode_q, mode_d;
`endif

    // One adder: mul adds the multiplicand, div subtracts the divisor.
    always_comb begin
        add_a  = {1'b0, hi_q};
        add_b  = lo_q[0] ? {1'b0, op2_q} : '0;
        add_ci = 1'b0;
`ifdef SEQ_ALU_DIV_EN
        if (mode_q) begin
            add_a  = {hi_q, lo_q[WIDTH-1]};
            add_b  = ~{1'b0, op2_q};
            add_ci = 1'b1;
        end
`endif
    end

    assign sum  = add_a + add_b + {{WIDTH{1'b0}}, add_ci};
    assign last = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        hi_nxt = sum[WIDTH:1];
        lo_nxt = {sum[0], lo_q[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
        // sum[WIDTH] set means the trial subtraction went negative: restore.
        if (mode_q) begin
            hi_nxt = sum[WIDTH] ? add_a[WIDTH-1:0] : sum[WIDTH-1:0];
            lo_nxt = {lo_q[WIDTH-2:0], ~sum[WIDTH]};
        end
`endif
    end

    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        op2_d = op2_q;
        cnt_d = cnt_q;
        if (load) begin
            hi_d  = '0;
            lo_d  = mode_in ? a : b;
            op2_d = mode_in ? b : a;
            cnt_d = '0;
        end else if (step) begin
            hi_d  = hi_nxt;
            lo_d  = lo_nxt;
            cnt_d = cnt_q + CW'(1);
        end
    end

`ifdef SEQ_ALU_DIV_EN
    assign mode_d = load ? mode_in : mode_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            op2_q  <= '0;
            cnt_q  <= '0;
`ifdef SEQ_ALU_DIV_EN
            mode_q <= 1'b0;
`endif
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            op2_q  <= op2_d;
            cnt_q  <= cnt_d;
`ifdef SEQ_ALU_DIV_EN
            mode_q <= mode_d;
`endif
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with start/done handshake, iterative mul and optional divu.
// Define SEQ_ALU_DIV_EN to build the divider; otherwise opcode 0111 is illegal.
module seq_alu import alu_defs::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int OPW   = DEF_OPW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [OPW-1:0]   opcode,
    input  logic [WIDTH-1:0] Rs,
    input  logic [WIDTH-1:0] Rt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Data_Out,
    output logic [WIDTH-1:0] Data_Hi,
    output logic             zeroFlag,
    output logic             negFlag,
    output logic             carryFlag,
    output logic             ovfFlag,
    output logic             errFlag
);
    state_t state_q, state_d;
    logic accept, is_mul, is_div, it_load, it_step, it_last, wr;
    logic [WIDTH-1:0] it_hi_nxt, it_lo_nxt;
    logic [WIDTH-1:0] out_q, out_d, hi_q, hi_d;
    logic zf_q, zf_d, nf_q, nf_d, cf_q, cf_d, of_q, of_d, ef_q, ef_d, dz_q, dz_d;
    logic [WIDTH:0] add_w, sub_w;

    assign accept = start && (state_q == S_IDLE || state_q == S_DONE);
    assign is_mul = (opcode == OPW'(OP_MUL));
`ifdef SEQ_ALU_DIV_EN
    assign is_div = (opcode == OPW'(OP_DIVU));
`else
    assign is_div = 1'b0;
`endif
    assign it_load = accept && (is_mul || is_div);
    assign it_step = (state_q == S_MUL) || (state_q == S_DIV);
    assign add_w   = {1'b0, Rs} + {1'b0, Rt};
    assign sub_w   = {1'b0, Rs} - {1'b0, Rt};

    seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk     (clk),
        .rst     (reset),
        .load    (it_load),
        .step    (it_step),
        .mode_in (is_div),
        .a       (Rs),
        .b       (Rt),
        .hi_nxt  (it_hi_nxt),
        .lo_nxt  (it_lo_nxt),
        .last    (it_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (!start)      state_d = S_IDLE;
                else if (is_mul) state_d = S_MUL;
                else if (is_div) state_d = S_DIV;
                else             state_d = S_DONE;
            end
            S_MUL, S_DIV: if (it_last) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = it_step;
        done = (state_q == S_DONE);
    end

    // Results and flags change only on the edge that enters DONE.
    always_comb begin
        out_d = out_q;
        hi_d  = hi_q;
        cf_d  = cf_q;
        of_d  = of_q;
        ef_d  = ef_q;
        dz_d  = dz_q;
        wr    = 1'b0;
        if (accept && !it_load) begin
            wr   = 1'b1;
            hi_d = '0;
            cf_d = 1'b0;
            of_d = 1'b0;
            ef_d = 1'b0;
            case (opcode)
                OPW'(OP_ADD): begin
                    out_d = add_w[WIDTH-1:0];
                    cf_d  = add_w[WIDTH];
                    of_d  = (Rs[WIDTH-1] == Rt[WIDTH-1]) && (add_w[WIDTH-1] != Rs[WIDTH-1]);
                end
                OPW'(OP_SUB): begin
                    out_d = sub_w[WIDTH-1:0];
                    cf_d  = sub_w[WIDTH];
                    of_d  = (Rs[WIDTH-1] != Rt[WIDTH-1]) && (sub_w[WIDTH-1] != Rs[WIDTH-1]);
                end
                OPW'(OP_AND): out_d = Rs & Rt;
                OPW'(OP_OR):  out_d = Rs | Rt;
                OPW'(OP_XOR): out_d = Rs ^ Rt;
                OPW'(OP_SLT): out_d = {{(WIDTH-1){1'b0}}, ($signed(Rs) < $signed(Rt))};
                default: begin
                    out_d = '0;
                    ef_d  = 1'b1;
                end
            endcase
        end else if (it_load) begin
            dz_d = is_div && (Rt == '0);
        end else if (it_step && it_last) begin
            wr    = 1'b1;
            out_d = (state_q == S_DIV && dz_q) ? '1 : it_lo_nxt;
            hi_d  = it_hi_nxt;
            cf_d  = 1'b0;
            of_d  = 1'b0;
            ef_d  = (state_q == S_DIV) && dz_q;
        end
        zf_d = wr ? (out_d == '0) : zf_q;
        nf_d = wr ? out_d[WIDTH-1] : nf_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= '0;
            hi_q  <= '0;
            zf_q  <= 1'b0;
            nf_q  <= 1'b0;
            cf_q  <= 1'b0;
            of_q  <= 1'b0;
            ef_q  <= 1'b0;
            dz_q  <= 1'b0;
        end else begin
            out_q <= out_d;
            hi_q  <= hi_d;
            zf_q  <= zf_d;
            nf_q  <= nf_d;
            cf_q  <= cf_d;
            of_q  <= of_d;
            ef_q  <= ef_d;
            dz_q  <= dz_d;
        end
    end

    assign Data_Out  = out_q;
    assign Data_Hi   = hi_q;
    assign zeroFlag  = zf_q;
    assign negFlag   = nf_q;
    assign carryFlag = cf_q;
    assign ovfFlag   = of_q;
    assign errFlag   = ef_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=32), covering both
// SEQ_ALU_DIV_EN build variants.
module tb_seq_alu;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [3:0]   opcode;
    logic [W-1:0] Rs, Rt;
    logic         busy, done, zeroFlag, negFlag, carryFlag, ovfFlag, errFlag;
    logic [W-1:0] Data_Out, Data_Hi;

    int total = 0;
    int bad   = 0;
    int lat;
    logic seen;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W), .OPW(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .opcode    (opcode),
        .Rs        (Rs),
        .Rt        (Rt),
        .busy      (busy),
        .done      (done),
        .Data_Out  (Data_Out),
        .Data_Hi   (Data_Hi),
        .zeroFlag  (zeroFlag),
        .negFlag   (negFlag),
        .carryFlag (carryFlag),
        .ovfFlag   (ovfFlag),
        .errFlag   (errFlag)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one request, then count cycles until done (bounded).
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int n);
        start = 1'b1; opcode = op; Rs = a; Rt = b; n = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            n++;
        end while (!done && n < 80);
        chk("done_seen", done, 1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; opcode = '0; Rs = '0; Rt = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out", Data_Out, 0);
        chk("rst_hi", Data_Hi, 0);
        chk("rst_flags", {zeroFlag, negFlag, carryFlag, ovfFlag, errFlag}, 0);
        reset = 1'b0;
        @(negedge clk);

        // reset in the middle of a multiply
        start = 1'b1; opcode = 4'b0010; Rs = 32'hFFFF_FFFF; Rt = 32'd3;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_busy", busy, 1);
        reset = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_out", Data_Out, 0);
        @(negedge clk); reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("abort_nodone", seen, 0);

        // sub
        run_op(4'b0001, 32'd5, 32'd5, lat);
        chk("sub0_lat", lat, 1);
        chk("sub0_out", Data_Out, 0);
        chk("sub0_zf_cf", {zeroFlag, carryFlag, negFlag}, 3'b100);
        @(negedge clk);
        chk("done_1cyc", done, 0);
        run_op(4'b0001, 32'd3, 32'd5, lat);
        chk("subn_out", Data_Out, 32'hFFFF_FFFE);
        chk("subn_flags", {zeroFlag, negFlag, carryFlag, ovfFlag}, 4'b0110);

        // add overflow / carry
        run_op(4'b0000, 32'h7FFF_FFFF, 32'd1, lat);
        chk("addo_out", Data_Out, 32'h8000_0000);
        chk("addo_flags", {ovfFlag, carryFlag, negFlag}, 3'b101);
        run_op(4'b0000, 32'hFFFF_FFFF, 32'd1, lat);
        chk("addc_out", Data_Out, 0);
        chk("addc_flags", {carryFlag, zeroFlag, ovfFlag}, 3'b110);

        // multiply, with a start during busy that must be ignored
        start = 1'b1; opcode = 4'b0010; Rs = 32'hFFFF_FFFF; Rt = 32'hFFFF_FFFF; lat = 0;
        do begin
            @(negedge clk);
            lat++;
            start = (lat == 10);
            if (start) begin opcode = 4'b0000; Rs = 32'd1; Rt = 32'd1; end
            if (lat == 5) chk("mul_hold_out", Data_Out, 0);
            if (lat == 10) chk("mul_busy", busy, 1);
        end while (!done && lat < 80);
        start = 1'b0;
        chk("mul_lat", lat, 33);
        chk("mul_hi", Data_Hi, 32'hFFFF_FFFE);
        chk("mul_lo", Data_Out, 32'h0000_0001);
        chk("mul_err", errFlag, 0);
        @(negedge clk);
        chk("mul_done_drop", done, 0);

`ifdef SEQ_ALU_DIV_EN
        run_op(4'b0111, 32'd100, 32'd7, lat);
        chk("div_lat", lat, 33);
        chk("div_q", Data_Out, 32'd14);
        chk("div_r", Data_Hi, 32'd2);
        chk("div_err", errFlag, 0);
        run_op(4'b0111, 32'd9, 32'd0, lat);
        chk("dz_lat", lat, 33);
        chk("dz_q", Data_Out, 32'hFFFF_FFFF);
        chk("dz_r", Data_Hi, 32'd9);
        chk("dz_err", errFlag, 1);
`else
        run_op(4'b0111, 32'd100, 32'd7, lat);
        chk("nodiv_lat", lat, 1);
        chk("nodiv_out", Data_Out, 0);
        chk("nodiv_err", errFlag, 1);
`endif

        // back-to-back issue from the DONE cycle
        run_op(4'b0000, 32'd2, 32'd3, lat);
        chk("b2b_add", Data_Out, 32'd5);
        chk("b2b_err", errFlag, 0);
        run_op(4'b0101, 32'hF0, 32'hFF, lat);
        chk("b2b_lat", lat, 1);
        chk("b2b_xor", Data_Out, 32'h0F);

        run_op(4'b1111, 32'd7, 32'd9, lat);
        chk("ill_lat", lat, 1);
        chk("ill_out", {Data_Out, Data_Hi}, 0);
        chk("ill_err", errFlag, 1);

        run_op(4'b0110, 32'hFFFF_FFFF, 32'd1, lat);
        chk("slt_out", Data_Out, 1);
        chk("slt_err", errFlag, 0);
        run_op(4'b0011, 32'hF0F0_1234, 32'h0FF0_FFFF, lat);
        chk("and_out", Data_Out, 32'h00F0_1234);
        run_op(4'b0100, 32'h8000_0000, 32'h1, lat);
        chk("or_out", Data_Out, 32'h8000_0001);
        chk("or_neg", negFlag, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the processor's combinational ALU.
- Adds a registered start/done handshake, iterative multiply and unsigned divide, a full flag set, and a high result word.
- Sits in the execute stage. The control unit stalls the PC while busy is high.
- Opcode encodings 0000/0001/0010 keep their existing meaning: add, sub, mul.

Parameters:
- WIDTH, 32, operand and result width in bits (legal range 8..64).
- OPW, 4, opcode width.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only when busy=0.
- opcode  in  OPW  operation select; sampled with start.
- Rs  in  WIDTH  operand A; sampled with start.
- Rt  in  WIDTH  operand B; sampled with start.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse; results are valid from this cycle onward.
- Data_Out  out  WIDTH  result (mul: low word; divu: quotient).
- Data_Hi  out  WIDTH  mul: high word; divu: remainder; all other ops: 0.
- zeroFlag  out  1  Data_Out == 0.
- negFlag  out  1  Data_Out[WIDTH-1].
- carryFlag  out  1  add: carry-out; sub: borrow (Rs<Rt unsigned); all other ops: 0.
- ovfFlag  out  1  signed overflow for add/sub; all other ops: 0.
- errFlag  out  1  illegal opcode, or divide by zero.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE. busy, done, all flags = 0. Data_Out and Data_Hi = 0. Reset mid-operation aborts it; no done pulse is produced.
- Opcodes:
  - 0000 add
  - 0001 sub
  - 0010 mul (unsigned, 2*WIDTH-bit product)
  - 0011 and
  - 0100 or
  - 0101 xor
  - 0110 slt (signed; result 1 or 0)
  - 0111 divu
  - all others illegal
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE or DONE, with start=1:
  - Single-cycle ops (add/sub/logic/slt/illegal): result and flags are registered at this edge, next state is DONE. done pulses 1 cycle after start.
  - mul: operands latched, counter=0, next state MUL, busy=1.
  - divu: same latch and counter reset, next state DIV, busy=1.
- MUL: radix-2 shift-add, one bit per cycle. Exits after WIDTH cycles to DONE. done is high exactly WIDTH+1 cycles after start.
- DIV: restoring division, one quotient bit per cycle. Same WIDTH+1 latency.
- DONE: done=1 for exactly one cycle. Next state is IDLE, or a new op if start=1 (back-to-back issue is allowed).
- start while busy=1 is ignored. Operands and opcode are not re-sampled.
- Outputs hold their last value until the next completing operation overwrites them. They do not change while busy.
- Illegal opcode: Data_Out=0, Data_Hi=0, errFlag=1. Completes in a single cycle.
- Divide by zero: Data_Out=all ones, Data_Hi=Rs, errFlag=1. Latency is unchanged (WIDTH+1).
- Flags update only on the done edge. zeroFlag and negFlag are computed for every op.
- Arithmetic is modulo 2^WIDTH. Carry and overflow are taken from a WIDTH+1-bit sum.

Optional Feature:
- SEQ_ALU_DIV_EN.
- Defined: divu is implemented as described above.
- Undefined: no divider logic is built. Opcode 0111 is treated as illegal: single cycle, Data_Out=0, errFlag=1.

Decomposition:
- Shared package/header (alu_defs) holds:
  - opcode localparams OP_ADD..OP_DIVU;
  - FSM state encodings;
  - default WIDTH.
- One sub-module: seq_alu_iter. It holds the shared shift/accumulate datapath, counter and mode bit (mul vs div), so mul and div reuse one WIDTH-bit adder.

Test Plan:
1. Reset mid-mul: assert reset at cycle 5 of a mul. Expect busy=0, done never pulses, Data_Out=0.
2. Sub, WIDTH=32, Rs=5, Rt=5 → done at +1 cycle, Data_Out=0, zeroFlag=1, carryFlag=0. Then Rs=3, Rt=5 → Data_Out=0xFFFFFFFE, negFlag=1, carryFlag=1.
3. Add overflow, 0x7FFFFFFF + 1 → Data_Out=0x80000000, ovfFlag=1, carryFlag=0. Also 0xFFFFFFFF + 1 → Data_Out=0, carryFlag=1, zeroFlag=1.
4. Mul, 0xFFFFFFFF × 0xFFFFFFFF → done exactly 33 cycles after start, Data_Hi=0xFFFFFFFE, Data_Out=0x00000001. A start pulsed at cycle 10 is ignored.
5. Divu (macro defined): 100/7 → Data_Out=14, Data_Hi=2, latency 33. 9/0 → Data_Out=0xFFFFFFFF, Data_Hi=9, errFlag=1. With the macro undefined, 100/7 → Data_Out=0, errFlag=1, latency 1.
6. Back-to-back: start with add 2+3 and, in the DONE cycle, start xor 0xF0 ^ 0xFF. Expect two consecutive done pulses with Data_Out=5, then 0x0F. Opcode 1111 → errFlag=1, Data_Out=0.
